// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side handshake bundle for the instruction cache.
// The cache sits on the slave modport; the fetcher/memory environment sits on master.
interface inst_cache_if;
    logic        start_fetch;
    logic [31:0] pc;
    logic        fetch_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    modport slave (
        input  start_fetch, pc, mem_ready, mem_data,
        output fetch_ready, inst, inst_addr, mem_req, mem_addr
    );

    modport master (
        output start_fetch, pc, mem_ready, mem_data,
        input  fetch_ready, inst, inst_addr, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache keyed on halfword PCs; one 32-bit word per line,
// misses filled by a single-word memory read, all outputs registered.
module inst_cache #(
    parameter  int INDEX_BITS = 6,
    localparam int TAG_BITS   = 31 - INDEX_BITS
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         rob_clear_up,
    inst_cache_if.slave  bus
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP      = 2'd1,
        MISS      = 2'd2,
        MISS_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        fetch_ready_q, fetch_ready_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [LINES-1:0] valid_q, valid_d;

    logic [31:0]         data_arr [LINES];
    logic [TAG_BITS-1:0] tag_arr  [LINES];

    logic [INDEX_BITS-1:0] pc_idx, fill_idx;
    logic [TAG_BITS-1:0]   pc_tag, fill_tag;
    logic                  hit;
    logic                  fill_en;
    logic                  unused_pc0;

    assign pc_idx     = bus.pc[INDEX_BITS:1];
    assign pc_tag     = bus.pc[31:INDEX_BITS+1];
    assign hit        = valid_q[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    assign unused_pc0 = bus.pc[0];

    // Fills are addressed from the registered request address so a PC change
    // after a flush cannot redirect the returning word into the wrong line.
    assign fill_idx = mem_addr_q[INDEX_BITS:1];
    assign fill_tag = mem_addr_q[31:INDEX_BITS+1];
    assign fill_en  = rdy_in && bus.mem_ready &&
                      ((state_q == MISS) || (state_q == MISS_DROP));

    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        assign valid_d[gi] = valid_q[gi] |
                             (fill_en && (fill_idx == INDEX_BITS'(gi)));
    end

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            data_arr[fill_idx] <= bus.mem_data;
            tag_arr[fill_idx]  <= fill_tag;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_ready_d = fetch_ready_q;
        inst_d        = inst_q;
        inst_addr_d   = inst_addr_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;

        if (rdy_in) begin
            fetch_ready_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rob_clear_up && bus.start_fetch) begin
                        if (hit) begin
                            inst_d        = data_arr[pc_idx];
                            inst_addr_d   = bus.pc;
                            fetch_ready_d = 1'b1;
                            state_d       = RESP;
                        end else begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = bus.pc;
                            state_d    = MISS;
                        end
                    end
                end
                // The fetcher still holds start_fetch here; ignoring it avoids a
                // second response for the same PC.
                RESP: state_d = IDLE;
                MISS: begin
                    if (bus.mem_ready) begin
                        mem_req_d = 1'b0;
                        if (rob_clear_up) begin
                            state_d = IDLE;
                        end else begin
                            inst_d        = bus.mem_data;
                            inst_addr_d   = mem_addr_q;
                            fetch_ready_d = 1'b1;
                            state_d       = RESP;
                        end
                    end else if (rob_clear_up) begin
                        state_d = MISS_DROP;
                    end
                end
                MISS_DROP: begin
                    if (bus.mem_ready) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            fetch_ready_q <= 1'b0;
            inst_q        <= '0;
            inst_addr_q   <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_ready_q <= fetch_ready_d;
            inst_q        <= inst_d;
            inst_addr_q   <= inst_addr_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            valid_q       <= valid_d;
        end
    end

    assign bus.fetch_ready = fetch_ready_q;
    assign bus.inst        = inst_q;
    assign bus.inst_addr   = inst_addr_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: stimulus pushes expected responses into a queue,
// an independent monitor pops and checks them whenever fetch_ready is seen.
module tb_inst_cache;
    logic clk_in       = 1'b0;
    logic rst_in       = 1'b1;
    logic rdy_in       = 1'b1;
    logic rob_clear_up = 1'b0;

    inst_cache_if bus();

    inst_cache dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rob_clear_up (rob_clear_up),
        .bus          (bus)
    );

    always #5 clk_in = ~clk_in;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic        prev_fr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every fetch_ready pulse must match the oldest expectation.
    always @(negedge clk_in) begin
        logic [63:0] e;
        if (bus.fetch_ready) begin
            n_cmp++;
            if (prev_fr) begin
                n_bad++;
                $display("FAIL fetch_ready_double: got high two cycles, expected single pulse (t=%0t)", $time);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: got inst=%h addr=%h, expected no response", bus.inst, bus.inst_addr);
            end else begin
                e = exp_q.pop_front();
                if ({bus.inst, bus.inst_addr} !== e) begin
                    n_bad++;
                    $display("FAIL resp: got inst=%h addr=%h, expected inst=%h addr=%h",
                             bus.inst, bus.inst_addr, e[63:32], e[31:0]);
                end else begin
                    $display("resp inst=%h addr=%h ok", bus.inst, bus.inst_addr);
                end
            end
        end
        prev_fr = bus.fetch_ready;
    end

    // Called at a negedge. Miss path returns `word` after `lat` cycles of mem_req.
    task automatic fetch(input logic [31:0] a, input bit miss, input int lat, input logic [31:0] word);
        exp_q.push_back({word, a});
        bus.start_fetch = 1'b1;
        bus.pc          = a;
        @(negedge clk_in);
        chk("mem_req_first", {31'd0, bus.mem_req}, {31'd0, miss});
        if (miss) begin
            chk("mem_addr", bus.mem_addr, a);
            for (int i = 1; i < lat; i++) begin
                @(negedge clk_in);
                chk("mem_req_hold", {31'd0, bus.mem_req}, 32'd1);
            end
            bus.mem_ready = 1'b1;
            bus.mem_data  = word;
            @(negedge clk_in);
            bus.mem_ready = 1'b0;
            chk("mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
        end
        chk("fetch_ready_rise", {31'd0, bus.fetch_ready}, 32'd1);
        bus.start_fetch = 1'b0;
        @(negedge clk_in);
        chk("fetch_ready_fall", {31'd0, bus.fetch_ready}, 32'd0);
    endtask

    initial begin
        bus.start_fetch = 1'b0;
        bus.pc          = '0;
        bus.mem_ready   = 1'b0;
        bus.mem_data    = '0;

        #2 rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rst_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_addr", bus.inst_addr, 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);

        $display("txn cold miss pc=0");
        fetch(32'h0000_0000, 1'b1, 5, 32'h0000_0513);
        $display("txn hit pc=0");
        fetch(32'h0000_0000, 1'b0, 0, 32'h0000_0513);
        $display("txn halfword miss pc=2");
        fetch(32'h0000_0002, 1'b1, 2, 32'h1111_2222);
        $display("txn hit pc=2");
        fetch(32'h0000_0002, 1'b0, 0, 32'h1111_2222);
        $display("txn conflict miss pc=82");
        fetch(32'h0000_0082, 1'b1, 3, 32'h3333_4444);
        $display("txn evicted miss pc=2");
        fetch(32'h0000_0002, 1'b1, 1, 32'h1111_2222);

        $display("txn flush during miss pc=104");
        bus.start_fetch = 1'b1;
        bus.pc          = 32'h0000_0104;
        @(negedge clk_in);
        chk("flush_req", {31'd0, bus.mem_req}, 32'd1);
        chk("flush_addr", bus.mem_addr, 32'h0000_0104);
        repeat (2) @(negedge clk_in);
        rob_clear_up    = 1'b1;
        bus.start_fetch = 1'b0;
        @(negedge clk_in);
        rob_clear_up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drop_req_hold", {31'd0, bus.mem_req}, 32'd1);
            @(negedge clk_in);
        end
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'hAAAA_0001;
        @(negedge clk_in);
        bus.mem_ready = 1'b0;
        chk("drop_req_release", {31'd0, bus.mem_req}, 32'd0);
        chk("drop_no_resp", {31'd0, bus.fetch_ready}, 32'd0);
        $display("txn hit after drop pc=104");
        fetch(32'h0000_0104, 1'b0, 0, 32'hAAAA_0001);

        $display("txn flush with mem_ready pc=108");
        bus.start_fetch = 1'b1;
        bus.pc          = 32'h0000_0108;
        @(negedge clk_in);
        chk("coin_req", {31'd0, bus.mem_req}, 32'd1);
        @(negedge clk_in);
        rob_clear_up    = 1'b1;
        bus.mem_ready   = 1'b1;
        bus.mem_data    = 32'hBBBB_0002;
        bus.start_fetch = 1'b0;
        @(negedge clk_in);
        rob_clear_up  = 1'b0;
        bus.mem_ready = 1'b0;
        chk("coin_no_resp", {31'd0, bus.fetch_ready}, 32'd0);
        chk("coin_req_drop", {31'd0, bus.mem_req}, 32'd0);
        $display("txn immediate hit pc=108");
        fetch(32'h0000_0108, 1'b0, 0, 32'hBBBB_0002);

        $display("txn rdy_in low mid-miss pc=10c");
        exp_q.push_back({32'hCCCC_0003, 32'h0000_010C});
        bus.start_fetch = 1'b1;
        bus.pc          = 32'h0000_010C;
        @(negedge clk_in);
        chk("frz_req", {31'd0, bus.mem_req}, 32'd1);
        rdy_in          = 1'b0;
        rob_clear_up    = 1'b1;
        bus.start_fetch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("frz_req_hold", {31'd0, bus.mem_req}, 32'd1);
            chk("frz_addr_hold", bus.mem_addr, 32'h0000_010C);
        end
        rdy_in          = 1'b1;
        rob_clear_up    = 1'b0;
        bus.start_fetch = 1'b1;
        bus.mem_ready   = 1'b1;
        bus.mem_data    = 32'hCCCC_0003;
        @(negedge clk_in);
        bus.mem_ready = 1'b0;
        chk("frz_resp", {31'd0, bus.fetch_ready}, 32'd1);
        bus.start_fetch = 1'b0;
        @(negedge clk_in);

        $display("txn async reset mid-miss pc=110");
        bus.start_fetch = 1'b1;
        bus.pc          = 32'h0000_0110;
        @(negedge clk_in);
        chk("ar_req", {31'd0, bus.mem_req}, 32'd1);
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        chk("ar_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("ar_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
        chk("ar_mem_addr", bus.mem_addr, 32'd0);
        chk("ar_inst", bus.inst, 32'd0);
        @(negedge clk_in);
        bus.start_fetch = 1'b0;
        rst_in          = 1'b1;
        @(negedge clk_in);
        $display("txn miss after reset pc=110");
        fetch(32'h0000_0110, 1'b1, 3, 32'hDDDD_0004);
        $display("txn miss after reset pc=0");
        fetch(32'h0000_0000, 1'b1, 2, 32'h0000_0513);

        repeat (2) @(negedge clk_in);
        chk("pending_resp", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL timeout: got no completion, expected finish before 100000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped instruction cache between the instruction fetcher and the memory controller.
- Accepts a fetch PC from the fetcher and returns the 32-bit instruction word at that PC, with a one-cycle `fetch_ready` pulse.
- Misses are served by a single-word read from the memory controller, and the fetched word is written into the line.
- Lines are keyed on halfword addresses, so an RVC 4-byte word that straddles a word boundary is cached as a unit.

Parameters:
- INDEX_BITS, 6, log2 of line count; 64 lines of 32 data bits each.
- TAG_BITS, 31-INDEX_BITS, tag width; derived, not overridable.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global ready; low freezes the block.
- rob_clear_up  in  1  ROB flush; discards any in-flight fetch.
- start_fetch  in  1  fetcher request; held high until fetch_ready is seen.
- pc  in  32  fetch address; bit 0 is always 0; stable while start_fetch is high.
- fetch_ready  out  1  one-cycle pulse; inst and inst_addr are valid.
- inst  out  32  instruction word, little-endian, bytes pc..pc+3.
- inst_addr  out  32  PC the word belongs to.
- mem_req  out  1  read request to the memory controller.
- mem_addr  out  32  byte address of the request; equals the missed pc.
- mem_ready  in  1  one-cycle pulse; mem_data is valid.
- mem_data  in  32  bytes mem_addr..mem_addr+3, little-endian.

Behaviour:
- Addressing:
  - idx = pc[INDEX_BITS:1]; tag = pc[31:INDEX_BITS+1].
  - hit = valid[idx] && tag_arr[idx]==tag.
- Reset (rst_in low, asynchronous):
  - All valid bits cleared; state = IDLE.
  - fetch_ready=0, inst=0, inst_addr=0, mem_req=0, mem_addr=0.
  - Data and tag arrays are not reset.
  - Reset mid-miss abandons the request; the memory controller is reset in the same domain.
- rdy_in low: no state, array, or output changes. The memory controller also freezes, so mem_ready is never 1 while rdy_in is low.
- All outputs are registered. FSM states:
  - IDLE:
    - If rob_clear_up: stay in IDLE.
    - Else if start_fetch and hit: load inst=data[idx] and inst_addr=pc, assert fetch_ready, go to RESP. Hit latency is 1 cycle.
    - Else if start_fetch and miss: mem_req=1, mem_addr=pc, go to MISS.
  - RESP: fetch_ready deasserts, go to IDLE; start_fetch is ignored in this cycle. The fetcher drops start_fetch on the edge where it sees fetch_ready, so RESP prevents a double response.
  - MISS:
    - mem_req is held at 1 until mem_ready.
    - On mem_ready: mem_req=0; write data[idx]=mem_data, tag_arr[idx]=tag, valid[idx]=1. Then set inst=mem_data, inst_addr=mem_addr, fetch_ready=1, go to RESP.
    - If rob_clear_up arrives before or with mem_ready, go to MISS_DROP; when mem_ready arrives in the same cycle as the flush, perform the MISS_DROP action instead.
  - MISS_DROP:
    - mem_req is held until mem_ready; a memory request is never withdrawn.
    - On mem_ready: fill the line as in MISS, no fetch_ready, go to IDLE.
    - A fresh start_fetch from the post-flush PC is not sampled until IDLE.
- rob_clear_up in RESP: fetch_ready forced to 0 next cycle, go to IDLE.
- rob_clear_up has priority over start_fetch in all states.
- Fill index and tag come from the registered mem_addr, not the live pc.
- Conflict eviction: a fill overwrites the line unconditionally.
- At most one memory request is outstanding.
- Invariant: fetch_ready is never high for 2 consecutive cycles.

Test Plan:
- Cold miss: reset, start_fetch=1, pc=0x0; memory returns 0x00000513 after 5 cycles.
  - mem_req=1 with mem_addr=0x0 until mem_ready.
  - Next cycle: fetch_ready=1, inst=0x00000513, inst_addr=0x0, for 1 cycle.
- Hit: re-fetch pc=0x0 after the cold miss.
  - fetch_ready is 1 the cycle after start_fetch is sampled, inst=0x00000513, mem_req stays 0.
- Halfword PC and conflict:
  - Fetch pc=0x2; must miss with mem_addr=0x2.
  - Then fetch pc=0x82, which has the same idx as 0x2 with INDEX_BITS=6; it must miss.
  - Re-fetch 0x2; it must miss again because the line was evicted.
- Flush during miss: rob_clear_up=1 two cycles after mem_req rises.
  - mem_req stays 1 until mem_ready; no fetch_ready.
  - A later fetch of the same pc hits in 1 cycle.
- Flush coincident with mem_ready: no fetch_ready; the line is filled; FSM is in IDLE the next cycle.
- rdy_in low for 3 cycles mid-miss, and async reset mid-miss:
  - rdy_in low: outputs hold.
  - Reset: mem_req=0 and fetch_ready=0 immediately; the prior pc misses after reset.
